pwm_clock_bank: RTL and testbench

PWM_CLOCK_BANK -- requirements
Module: pwm_clock_bank

---
 rtl/pwm_clock_bank.sv | 126 ++++++++++++
 tb/tb_pwm_clock_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_clock_bank.sv
// Bank of independent PWM clock generators whose period/duty updates are shadowed and
// only take effect at a period boundary. Define PWM_CLOCK_BANK_INVERT_EN to add cfg_invert.
module pwm_clock_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                fast_clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_duty,
`ifdef PWM_CLOCK_BANK_INVERT_EN
    input  logic                cfg_invert,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] period_tick
);

    logic [WIDTH-1:0]    act_period [CHANNELS];
    logic [WIDTH-1:0]    act_duty   [CHANNELS];
    logic [WIDTH-1:0]    shd_period [CHANNELS];
    logic [WIDTH-1:0]    shd_duty   [CHANNELS];
    logic [WIDTH-1:0]    count      [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] level;
    logic                chan_in_range;
    logic                sel_pending;
`ifdef PWM_CLOCK_BANK_INVERT_EN
    logic [CHANNELS-1:0] act_invert;
    logic [CHANNELS-1:0] shd_invert;
`endif

    // Out-of-range channels are always ready so such writes drain harmlessly.
    always_comb begin
        chan_in_range = (32'(cfg_chan) < 32'(CHANNELS));
        sel_pending   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CW'(i)) begin
                sel_pending = pending[i];
            end
        end
        cfg_ready = chan_in_range ? (!rst && !sel_pending) : 1'b1;
        wr_hit = '0;
        wrap   = '0;
        level  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
            wrap[i]   = (count[i] == (act_period[i] - WIDTH'(1)));
`ifdef PWM_CLOCK_BANK_INVERT_EN
            level[i]  = (count[i] < act_duty[i]) ^ act_invert[i];
`else
            level[i]  = (count[i] < act_duty[i]);
`endif
        end
    end

    // A write can only land while pending is clear and an update only applies while it is
    // set, so the two never collide on the same channel in one cycle.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                act_period[i] <= '0;
                act_duty[i]   <= '0;
                shd_period[i] <= '0;
                shd_duty[i]   <= '0;
                count[i]      <= '0;
            end
            pending     <= '0;
            clk_out     <= '0;
            period_tick <= '0;
`ifdef PWM_CLOCK_BANK_INVERT_EN
            act_invert  <= '0;
            shd_invert  <= '0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit[i]) begin
                    shd_period[i] <= cfg_period;
                    shd_duty[i]   <= cfg_duty;
                    pending[i]    <= 1'b1;
`ifdef PWM_CLOCK_BANK_INVERT_EN
                    shd_invert[i] <= cfg_invert;
`endif
                end
                if (act_period[i] == '0) begin
                    count[i]       <= '0;
                    clk_out[i]     <= 1'b0;
                    period_tick[i] <= 1'b0;
                    if (pending[i]) begin
                        act_period[i] <= shd_period[i];
                        act_duty[i]   <= shd_duty[i];
                        pending[i]    <= 1'b0;
`ifdef PWM_CLOCK_BANK_INVERT_EN
                        act_invert[i] <= shd_invert[i];
`endif
                    end
                end else if (enable) begin
                    period_tick[i] <= wrap[i];
                    clk_out[i]     <= level[i];
                    if (wrap[i]) begin
                        count[i] <= '0;
                        if (pending[i]) begin
                            act_period[i] <= shd_period[i];
                            act_duty[i]   <= shd_duty[i];
                            pending[i]    <= 1'b0;
`ifdef PWM_CLOCK_BANK_INVERT_EN
                            act_invert[i] <= shd_invert[i];
`endif
                        end
                    end else begin
                        count[i] <= count[i] + WIDTH'(1);
                    end
                end else begin
                    period_tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_clock_bank.sv
// Scoreboard bench for pwm_clock_bank: directed writes push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pwm_clock_bank;

    logic       fast_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
`ifdef PWM_CLOCK_BANK_INVERT_EN
    logic       cfg_invert;
`endif
    logic [3:0] clk_out;
    logic [3:0] period_tick;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] ch;
        logic [7:0] exp;
    } item_t;

    item_t sb[$];
    string sb_name[$];
    int    compared   = 0;
    int    mismatched = 0;
    item_t mon_item;
    string mon_name;
    logic [7:0] mon_act;

    pwm_clock_bank #(.WIDTH(8), .CHANNELS(4), .CW(2)) dut (
        .fast_clk    (fast_clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
`ifdef PWM_CLOCK_BANK_INVERT_EN
        .cfg_invert  (cfg_invert),
`endif
        .clk_out     (clk_out),
        .period_tick (period_tick)
    );

    always #5 fast_clk = ~fast_clk;

    // kind 0: one channel {clk,tick}; kind 1: cfg_ready; kind 2: full {clk_out,period_tick}.
    always @(negedge fast_clk) begin
        while (sb.size() > 0) begin
            mon_item = sb.pop_front();
            mon_name = sb_name.pop_front();
            case (mon_item.kind)
                2'd0:    mon_act = {6'b0, clk_out[mon_item.ch], period_tick[mon_item.ch]};
                2'd1:    mon_act = {7'b0, cfg_ready};
                default: mon_act = {clk_out, period_tick};
            endcase
            compared++;
            if (mon_act !== mon_item.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", mon_name, mon_act, mon_item.exp);
            end
        end
    end

    task automatic step();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic check_output(input string nm, input int kind, input int ch, input logic [7:0] exp);
        item_t it;
        it.kind = 2'(kind);
        it.ch   = 2'(ch);
        it.exp  = exp;
        sb.push_back(it);
        sb_name.push_back(nm);
    endtask

    task automatic expect_ch(input string nm, input int ch, input bit c, input bit t);
        check_output(nm, 0, ch, {6'b0, c, t});
    endtask

    task automatic expect_ready(input string nm, input bit r);
        check_output(nm, 1, 0, {7'b0, r});
    endtask

    task automatic apply_stimulus(input int ch, input int p, input int d);
        cfg_valid  = 1'b1;
        cfg_chan   = 2'(ch);
        cfg_period = 8'(p);
        cfg_duty   = 8'(d);
    endtask

    task automatic release_cfg();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_chan   = 2'd0;
        cfg_period = 8'd0;
        cfg_duty   = 8'd0;
`ifdef PWM_CLOCK_BANK_INVERT_EN
        cfg_invert = 1'b0;
`endif
        step();
        expect_ready("ready during reset", 1'b0);
        step();
        rst = 1'b0;
        check_output("outputs after reset", 2, 0, 8'h00);
        expect_ready("ready after reset", 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit [21:0] s1_clk;
        bit [21:0] s1_tick;
        bit [16:0] s2_clk;
        bit [16:0] s2_tick;
        bit [22:0] s3_clk;
        bit [22:0] s3_tick;
        bit [18:0] s4_clk;
        bit [18:0] s4_tick;

        // ch0 P=4 D=1, then a write landing exactly on a wrap edge (P=2 D=2) defers one period.
        do_reset();
        enable = 1'b1;
        apply_stimulus(0, 4, 1);
        expect_ready("s1 write ready", 1'b1);
        step();
        release_cfg();
        expect_ch("s1 e0", 0, 1'b0, 1'b0);
        s1_clk  = 22'b1111_0001_0001_0001_0001_00;
        s1_tick = 22'b1010_1000_1000_1000_1000_00;
        for (int n = 1; n <= 21; n++) begin
            step();
            if (n == 12) begin
                apply_stimulus(0, 2, 2);
                expect_ready("s1 wrap write ready", 1'b1);
            end
            if (n == 13) begin
                release_cfg();
                expect_ready("s1 pending stall", 1'b0);
            end
            if (n == 17) expect_ready("s1 pending cleared", 1'b1);
            expect_ch($sformatf("s1 ch0 e%0d", n), 0, s1_clk[n], s1_tick[n]);
        end

        // ch1 P=10 D=5 updated at counter 3; stalled rewrite of ch1, ch2 still accepted.
        do_reset();
        enable = 1'b1;
        apply_stimulus(1, 10, 5);
        expect_ready("s2 write ready", 1'b1);
        step();
        release_cfg();
        expect_ch("s2 f0", 1, 1'b0, 1'b0);
        s2_clk  = 17'b1_0011_0000_0111_1100;
        s2_tick = 17'b0_1000_1000_0000_0000;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (n == 4) begin
                apply_stimulus(1, 4, 2);
                expect_ready("s2 update ready", 1'b1);
            end
            if (n == 5) begin
                apply_stimulus(1, 7, 7);
                expect_ready("s2 ch1 stalled", 1'b0);
            end
            if (n == 6) begin
                apply_stimulus(2, 3, 1);
                expect_ready("s2 ch2 accepted", 1'b1);
            end
            if (n == 7) begin
                release_cfg();
                cfg_chan = 2'd1;
            end
            if (n >= 7 && n <= 11) expect_ready($sformatf("s2 ch1 ready f%0d", n), n == 11);
            expect_ch($sformatf("s2 ch1 f%0d", n), 1, s2_clk[n], s2_tick[n]);
            if (n == 9)  expect_ch("s2 ch2 f9", 2, 1'b1, 1'b0);
            if (n == 11) expect_ch("s2 ch2 f11", 2, 1'b0, 1'b1);
        end

        // ch0 boundaries: D=0, D=P, P=1, then P=0 idle.
        do_reset();
        enable = 1'b1;
        apply_stimulus(0, 5, 0);
        expect_ready("s3 write ready", 1'b1);
        step();
        release_cfg();
        expect_ch("s3 g0", 0, 1'b0, 1'b0);
        s3_clk  = 23'b000_1111_1111_0000_0000_0000;
        s3_tick = 23'b000_1111_0000_1000_0100_0000;
        for (int n = 1; n <= 22; n++) begin
            step();
            if (n == 7)  apply_stimulus(0, 5, 5);
            if (n == 12) apply_stimulus(0, 1, 1);
            if (n == 17) apply_stimulus(0, 0, 0);
            if (n == 7 || n == 12 || n == 17) expect_ready($sformatf("s3 ready g%0d", n), 1'b1);
            if (n == 8 || n == 13 || n == 18) release_cfg();
            expect_ch($sformatf("s3 ch0 g%0d", n), 0, s3_clk[n], s3_tick[n]);
        end

        // ch3 P=6 D=3 frozen for 7 cycles at counter 2, with a write absorbed during the freeze.
        do_reset();
        enable = 1'b1;
        apply_stimulus(3, 6, 3);
        expect_ready("s4 write ready", 1'b1);
        step();
        release_cfg();
        expect_ch("s4 h0", 3, 1'b0, 1'b0);
        s4_clk  = 19'b000_0000_1111_1111_1100;
        s4_tick = 19'b101_0100_0000_0000_0000;
        for (int n = 1; n <= 18; n++) begin
            step();
            if (n == 3)  enable = 1'b0;
            if (n == 10) enable = 1'b1;
            if (n == 5) begin
                apply_stimulus(3, 2, 0);
                expect_ready("s4 frozen write ready", 1'b1);
            end
            if (n == 6) begin
                release_cfg();
                cfg_chan = 2'd3;
                expect_ready("s4 frozen pending", 1'b0);
            end
            expect_ch($sformatf("s4 ch3 h%0d", n), 3, s4_clk[n], s4_tick[n]);
        end

        // Reset with a pending write outstanding and a write presented during reset.
        apply_stimulus(3, 6, 6);
        expect_ready("s4 pre-reset write ready", 1'b1);
        step();
        rst = 1'b1;
        apply_stimulus(3, 1, 1);
        expect_ready("s4 ready in reset", 1'b0);
        expect_ch("s4 h19", 3, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        release_cfg();
        cfg_chan = 2'd3;
        check_output("s4 outputs after mid reset", 2, 0, 8'h00);
        expect_ready("s4 pending discarded", 1'b1);
        for (int n = 21; n <= 23; n++) begin
            step();
            expect_ch($sformatf("s4 idle h%0d", n), 3, 1'b0, 1'b0);
        end

`ifdef PWM_CLOCK_BANK_INVERT_EN
        // Inverted ch0 P=4 D=1 gives 0,1,1,1.
        do_reset();
        enable = 1'b1;
        cfg_invert = 1'b1;
        apply_stimulus(0, 4, 1);
        step();
        release_cfg();
        cfg_invert = 1'b0;
        step();
        expect_ch("s5 i1", 0, 1'b0, 1'b0);
        step();
        expect_ch("s5 i2", 0, 1'b0, 1'b0);
        step();
        expect_ch("s5 i3", 0, 1'b1, 1'b0);
        step();
        expect_ch("s5 i4", 0, 1'b1, 1'b0);
        step();
        expect_ch("s5 i5", 0, 1'b1, 1'b1);
        step();
        expect_ch("s5 i6", 0, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge fast_clk);
        #1;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard drain: %0d items left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
